// File: rtl/tlb_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlb_pkg
// Description : Shared types and entry field positions for the TLB
//               maintenance sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package tlb_pkg;

    localparam int TLB_ENTRIES  = 16;
    localparam int TLB_IDX_W    = 4;
    localparam int TLB_ENTRY_W  = 86;

    localparam int TLB_VPN2_MSB = 85;
    localparam int TLB_VPN2_LSB = 67;
    localparam int TLB_G_BIT    = 66;
    localparam int TLB_ASID_MSB = 65;
    localparam int TLB_ASID_LSB = 58;
    localparam int TLB_LO0_MSB  = 57;
    localparam int TLB_LO0_LSB  = 29;
    localparam int TLB_LO1_MSB  = 28;
    localparam int TLB_LO1_LSB  = 0;

    typedef enum logic [1:0] {
        OP_TLBR  = 2'd0,
        OP_TLBWI = 2'd1,
        OP_TLBWR = 2'd2,
        OP_TLBP  = 2'd3
    } tlb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WRITE    = 3'd3,
        ST_PROBE    = 3'd4,
        ST_DONE     = 3'd5
    } tlb_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/tlb_random_counter.sv
`default_nettype none
// ============================================================================
// Module      : tlb_random_counter
// Description : CP0 Random register; free-running down-counter bounded below
//               by Wired and reloaded to the top entry on any Wired write.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_random_counter #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             cp0_wired_we,
    output logic [IDX_W-1:0] random_index
);

    localparam logic [IDX_W-1:0] c_TOP = '1;

    logic [IDX_W-1:0] r_random;

    // Wrap when the next decrement would enter the wired region.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_random <= c_TOP;
        end else if (cp0_wired_we || (r_random <= cp0_wired)) begin
            r_random <= c_TOP;
        end else begin
            r_random <= r_random - IDX_W'(1);
        end
    end

    assign random_index = r_random;

endmodule
`default_nettype wire

// File: rtl/tlb_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tlb_op_sequencer
// Description : Multi-cycle sequencer for TLBR/TLBWI/TLBWR/TLBP, driving the
//               TLB maintenance port and the CP0 update strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_op_sequencer
    import tlb_pkg::*;
#(
    parameter  int NUM_ENTRIES = TLB_ENTRIES,
    parameter  int ENTRY_W     = TLB_ENTRY_W,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [1:0]         op_type,
    output logic               op_ready,
    input  logic [IDX_W-1:0]   cp0_index,
    input  logic [IDX_W-1:0]   cp0_wired,
    input  logic               cp0_wired_we,
    input  logic [ENTRY_W-1:0] cp0_entry,
    output logic               tlb_rd_en,
    output logic [IDX_W-1:0]   tlb_rd_idx,
    input  logic [ENTRY_W-1:0] tlb_rd_data,
    output logic               tlb_wr_en,
    output logic [IDX_W-1:0]   tlb_wr_idx,
    output logic [ENTRY_W-1:0] tlb_wr_data,
    output logic               cp0_tlbr,
    output logic [ENTRY_W-1:0] tlbr_data,
    output logic               cp0_tlbp,
    output logic               probe_miss,
    output logic [IDX_W-1:0]   probe_index,
    output logic [IDX_W-1:0]   random_index,
    output logic               busy,
    output logic               done
);

    localparam int c_CNT_W = IDX_W + 1;

    tlb_seq_state_e     r_state;
    tlb_seq_state_e     w_next_state;
    logic [IDX_W-1:0]   r_wr_idx;
    logic [c_CNT_W-1:0] r_probe_cnt;

    tlb_op_e            w_op;
    logic               w_accept;
    logic               w_cmp_valid;
    logic               w_scan_end;
    logic               w_hit;
    logic [IDX_W-1:0]   w_cmp_idx;

    assign w_op     = tlb_op_e'(op_type);
    assign w_accept = op_valid && (r_state == ST_IDLE);

    tlb_random_counter #(
        .IDX_W        (IDX_W)
    ) u_random (
        .clk          (clk),
        .rst          (rst),
        .cp0_wired    (cp0_wired),
        .cp0_wired_we (cp0_wired_we),
        .random_index (random_index)
    );

    // Probe pipeline: count k issues read k and compares the data of read k-1.
    assign w_cmp_valid = (r_probe_cnt != '0);
    assign w_scan_end  = (r_probe_cnt == c_CNT_W'(NUM_ENTRIES));
    assign w_cmp_idx   = r_probe_cnt[IDX_W-1:0] - IDX_W'(1);
    assign w_hit       = (r_state == ST_PROBE) && w_cmp_valid
                      && (tlb_rd_data[TLB_VPN2_MSB:TLB_VPN2_LSB] ==
                          cp0_entry[TLB_VPN2_MSB:TLB_VPN2_LSB])
                      && (tlb_rd_data[TLB_G_BIT] ||
                          (tlb_rd_data[TLB_ASID_MSB:TLB_ASID_LSB] ==
                           cp0_entry[TLB_ASID_MSB:TLB_ASID_LSB]));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    case (w_op)
                        OP_TLBR:  w_next_state = ST_RD_ISSUE;
                        OP_TLBWI: w_next_state = ST_WRITE;
                        OP_TLBWR: w_next_state = ST_WRITE;
                        default:  w_next_state = ST_PROBE;
                    endcase
                end
            end
            ST_RD_ISSUE: w_next_state = ST_RD_WAIT;
            ST_RD_WAIT:  w_next_state = ST_IDLE;
            ST_WRITE:    w_next_state = ST_IDLE;
            ST_PROBE: begin
                if (w_hit || w_scan_end) begin
                    w_next_state = ST_IDLE;
                end
            end
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // TLBWR takes Random as it stands at the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx    <= '0;
            r_probe_cnt <= '0;
        end else begin
            if (w_accept && (w_op == OP_TLBWI)) begin
                r_wr_idx <= cp0_index;
            end else if (w_accept && (w_op == OP_TLBWR)) begin
                r_wr_idx <= random_index;
            end

            if (w_accept) begin
                r_probe_cnt <= '0;
            end else if (r_state == ST_PROBE) begin
                r_probe_cnt <= r_probe_cnt + c_CNT_W'(1);
            end
        end
    end

    // Strobes are suppressed while reset is held so nothing leaks out
    // of an operation that is being aborted.
    always_comb begin
        tlb_rd_en   = 1'b0;
        tlb_rd_idx  = '0;
        tlb_wr_en   = 1'b0;
        tlb_wr_data = '0;
        cp0_tlbr    = 1'b0;
        tlbr_data   = '0;
        cp0_tlbp    = 1'b0;
        probe_miss  = 1'b0;
        probe_index = '0;
        done        = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_RD_ISSUE: begin
                    tlb_rd_en  = 1'b1;
                    tlb_rd_idx = cp0_index;
                end
                ST_RD_WAIT: begin
                    tlbr_data = tlb_rd_data;
                    cp0_tlbr  = 1'b1;
                    done      = 1'b1;
                end
                ST_WRITE: begin
                    tlb_wr_en   = 1'b1;
                    tlb_wr_data = cp0_entry;
                    done        = 1'b1;
                end
                ST_PROBE: begin
                    tlb_rd_en  = !w_scan_end;
                    tlb_rd_idx = r_probe_cnt[IDX_W-1:0];
                    if (w_hit) begin
                        cp0_tlbp    = 1'b1;
                        probe_index = w_cmp_idx;
                        done        = 1'b1;
                    end else if (w_scan_end) begin
                        cp0_tlbp   = 1'b1;
                        probe_miss = 1'b1;
                        done       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tlb_wr_idx = r_wr_idx;
    assign op_ready   = (r_state == ST_IDLE);
    assign busy       = !op_ready;

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_op_sequencer
// Description : Self-checking bench for tlb_op_sequencer with a TLB array
//               model and a reference model for probe and Random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_op_sequencer;
    import tlb_pkg::*;

    typedef struct packed {
        logic [18:0] vpn2;
        logic        g;
        logic [7:0]  asid;
        logic [28:0] lo0;
        logic [28:0] lo1;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [1:0]  op_type = 2'd0;
    logic [3:0]  cp0_index = 4'd0;
    logic [3:0]  cp0_wired = 4'd0;
    logic        cp0_wired_we = 1'b0;
    logic [85:0] cp0_entry = '0;
    logic [85:0] tlb_rd_data = '0;
    logic        op_ready, tlb_rd_en, tlb_wr_en, cp0_tlbr, cp0_tlbp;
    logic        probe_miss, busy, done;
    logic [3:0]  tlb_rd_idx, tlb_wr_idx, probe_index, random_index;
    logic [85:0] tlb_wr_data, tlbr_data;

    logic [85:0] mem [16];
    logic [3:0]  m_rand = 4'd15;
    bit          mon_en = 1'b0;
    int          mon_prints = 0;
    int          checks = 0;
    int          errors = 0;

    int          o_wr_cyc, o_rd_cyc, o_tlbr_cyc, o_tlbp_cyc;
    int          o_done_cnt, o_done_cyc, o_ready_cyc, o_excl;
    logic [3:0]  o_wr_idx, o_rd_idx, o_probe_idx;
    logic        o_miss;
    logic [85:0] o_wr_data, o_tlbr_data;

    tlb_op_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_type      (op_type),
        .op_ready     (op_ready),
        .cp0_index    (cp0_index),
        .cp0_wired    (cp0_wired),
        .cp0_wired_we (cp0_wired_we),
        .cp0_entry    (cp0_entry),
        .tlb_rd_en    (tlb_rd_en),
        .tlb_rd_idx   (tlb_rd_idx),
        .tlb_rd_data  (tlb_rd_data),
        .tlb_wr_en    (tlb_wr_en),
        .tlb_wr_idx   (tlb_wr_idx),
        .tlb_wr_data  (tlb_wr_data),
        .cp0_tlbr     (cp0_tlbr),
        .tlbr_data    (tlbr_data),
        .cp0_tlbp     (cp0_tlbp),
        .probe_miss   (probe_miss),
        .probe_index  (probe_index),
        .random_index (random_index),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Array model: one-cycle read latency.
    always @(posedge clk) begin
        if (tlb_rd_en) tlb_rd_data <= mem[tlb_rd_idx];
    end

    // Random reference: counts down, reloads to 15 on reset, Wired write,
    // or once the value has reached Wired.
    always @(posedge clk) begin
        if (rst || cp0_wired_we || (int'(m_rand) <= int'(cp0_wired))) m_rand <= 4'd15;
        else m_rand <= 4'(int'(m_rand) - 1);
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (random_index !== m_rand) begin
                errors++;
                if (mon_prints < 10) begin
                    mon_prints++;
                    $display("FAIL random_track t=%0t: got %0d expected %0d", $time, random_index, m_rand);
                end
            end
        end
    end

    function automatic logic [85:0] rand86();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[85:0];
    endfunction

    function automatic int ref_probe(input logic [85:0] probe);
        ent_t p, e;
        p = probe;
        for (int i = 0; i < 16; i++) begin
            e = mem[i];
            if (e.vpn2 == p.vpn2 && (e.g || e.asid == p.asid)) return i;
        end
        return -1;
    endfunction

    task automatic issue(input logic [1:0] t, input logic [3:0] idx, input logic [85:0] ent, input bit keep);
        op_valid  = 1'b1;
        op_type   = t;
        cp0_index = idx;
        cp0_entry = ent;
        @(posedge clk); #1;
        if (!keep) op_valid = 1'b0;
    endtask

    // Records what happens from cycle t0+1 until op_ready returns.
    task automatic observe(input int max_cyc);
        o_wr_cyc = -1; o_rd_cyc = -1; o_tlbr_cyc = -1; o_tlbp_cyc = -1;
        o_done_cnt = 0; o_done_cyc = -1; o_ready_cyc = -1; o_excl = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            if ((int'(cp0_tlbr) + int'(cp0_tlbp) + int'(tlb_wr_en)) > 1 || (tlb_rd_en && tlb_wr_en)) o_excl++;
            if (tlb_wr_en === 1'b1 && o_wr_cyc < 0) begin
                o_wr_cyc = c; o_wr_idx = tlb_wr_idx; o_wr_data = tlb_wr_data;
            end
            if (tlb_rd_en === 1'b1 && o_rd_cyc < 0) begin
                o_rd_cyc = c; o_rd_idx = tlb_rd_idx;
            end
            if (cp0_tlbr === 1'b1 && o_tlbr_cyc < 0) begin
                o_tlbr_cyc = c; o_tlbr_data = tlbr_data;
            end
            if (cp0_tlbp === 1'b1 && o_tlbp_cyc < 0) begin
                o_tlbp_cyc = c; o_miss = probe_miss; o_probe_idx = probe_index;
            end
            if (done === 1'b1) begin
                o_done_cnt++; o_done_cyc = c;
            end
            if (op_ready === 1'b1) begin
                o_ready_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_rand(input logic [3:0] val, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (m_rand == val) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({op_ready, busy, random_index} !== {1'b1, 1'b0, 4'd15}) begin
            errors++;
            $display("FAIL reset_status: ready/busy/random got %b/%b/%0d expected 1/0/15", op_ready, busy, random_index);
        end
        checks++;
        if ({tlb_rd_en, tlb_wr_en, cp0_tlbr, cp0_tlbp, done, probe_miss} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 000000", {tlb_rd_en, tlb_wr_en, cp0_tlbr, cp0_tlbp, done, probe_miss});
        end
        checks++;
        if ({tlb_rd_idx, tlb_wr_idx, probe_index, tlbr_data, tlb_wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: rd_idx=%0d wr_idx=%0d probe_idx=%0d tlbr=%h wr=%h expected all 0",
                     tlb_rd_idx, tlb_wr_idx, probe_index, tlbr_data, tlb_wr_data);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_tlbwi();
        logic [85:0] ent;
        ent = rand86();
        ent[85:78] = 8'h2A;
        issue(OP_TLBWI, 4'd5, ent, 1'b0);
        observe(10);
        checks++;
        if (o_wr_cyc != 1 || o_wr_idx !== 4'd5) begin
            errors++;
            $display("FAIL tlbwi_write: cycle %0d idx %0d expected cycle 1 idx 5", o_wr_cyc, o_wr_idx);
        end
        checks++;
        if (o_wr_data !== ent) begin
            errors++;
            $display("FAIL tlbwi_data: got %h expected %h", o_wr_data, ent);
        end
        checks++;
        if (o_done_cnt != 1 || o_done_cyc != 1 || o_ready_cyc != 2) begin
            errors++;
            $display("FAIL tlbwi_timing: done_cnt %0d done_cyc %0d ready_cyc %0d expected 1/1/2", o_done_cnt, o_done_cyc, o_ready_cyc);
        end
        checks++;
        if (o_rd_cyc != -1 || o_excl != 0) begin
            errors++;
            $display("FAIL tlbwi_side: rd_cyc %0d excl %0d expected -1/0", o_rd_cyc, o_excl);
        end
    endtask

    task automatic test_tlbr();
        logic [85:0] x;
        for (int i = 0; i < 16; i++) mem[i] = rand86();
        x = rand86();
        mem[9] = x;
        issue(OP_TLBR, 4'd9, rand86(), 1'b0);
        observe(10);
        checks++;
        if (o_rd_cyc != 1 || o_rd_idx !== 4'd9) begin
            errors++;
            $display("FAIL tlbr_read: cycle %0d idx %0d expected cycle 1 idx 9", o_rd_cyc, o_rd_idx);
        end
        checks++;
        if (o_tlbr_cyc != 2 || o_tlbr_data !== x) begin
            errors++;
            $display("FAIL tlbr_strobe: cycle %0d data %h expected cycle 2 data %h", o_tlbr_cyc, o_tlbr_data, x);
        end
        checks++;
        if (o_done_cnt != 1 || o_done_cyc != 2 || o_ready_cyc != 3 || o_wr_cyc != -1 || o_excl != 0) begin
            errors++;
            $display("FAIL tlbr_timing: done %0d@%0d ready %0d wr %0d excl %0d expected 1@2 3 -1 0",
                     o_done_cnt, o_done_cyc, o_ready_cyc, o_wr_cyc, o_excl);
        end
    endtask

    task automatic run_probe_check(input string name, input logic [85:0] probe);
        int m, exp_cyc;
        m = ref_probe(probe);
        exp_cyc = (m < 0) ? 17 : m + 2;
        issue(OP_TLBP, 4'd0, probe, 1'b0);
        observe(25);
        checks++;
        if (o_tlbp_cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s_cycle: cp0_tlbp at %0d expected %0d", name, o_tlbp_cyc, exp_cyc);
        end
        checks++;
        if (o_miss !== (m < 0) || o_probe_idx !== ((m < 0) ? 4'd0 : 4'(m))) begin
            errors++;
            $display("FAIL %s_result: miss %b idx %0d expected miss %0d idx %0d", name, o_miss, o_probe_idx, (m < 0), (m < 0) ? 0 : m);
        end
        checks++;
        if (o_done_cnt != 1 || o_ready_cyc != exp_cyc + 1 || o_wr_cyc != -1 || o_excl != 0) begin
            errors++;
            $display("FAIL %s_side: done %0d ready %0d wr %0d excl %0d expected 1 %0d -1 0",
                     name, o_done_cnt, o_ready_cyc, o_wr_cyc, o_excl, exp_cyc + 1);
        end
    endtask

    task automatic test_tlbp_directed();
        ent_t p, e;
        p = rand86();
        p.g = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e = rand86();
            e.vpn2 = ~p.vpn2;
            mem[i] = e;
        end
        e = rand86(); e.vpn2 = p.vpn2; e.g = 1'b0; e.asid = p.asid;       mem[3] = e;
        e = rand86(); e.vpn2 = p.vpn2; e.g = 1'b1; e.asid = ~p.asid;      mem[7] = e;
        run_probe_check("tlbp_hit3", p);
        // Same VPN2, different ASID, not global: must not match.
        mem[3] = ~mem[3];
        e = rand86(); e.vpn2 = p.vpn2; e.g = 1'b0; e.asid = p.asid ^ 8'h5A; mem[7] = e;
        run_probe_check("tlbp_miss", p);
        e = rand86(); e.vpn2 = p.vpn2; e.g = 1'b0; e.asid = p.asid;       mem[15] = e;
        run_probe_check("tlbp_hit15", p);
    endtask

    task automatic test_tlbp_random();
        ent_t p, e;
        for (int it = 0; it < 12; it++) begin
            p = rand86();
            p.asid = 8'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) begin
                e = rand86();
                e.vpn2 = ($urandom_range(0, 2) == 0) ? p.vpn2 : p.vpn2 ^ 19'($urandom_range(1, 3));
                e.g = ($urandom_range(0, 3) == 0);
                e.asid = 8'($urandom_range(0, 3));
                mem[i] = e;
            end
            run_probe_check("tlbp_rand", p);
        end
    endtask

    task automatic test_random_wired();
        bit ok;
        int exp_v;
        logic [85:0] ent;
        logic [3:0] exp_idx;
        cp0_wired = 4'd4;
        @(posedge clk); #1;
        wait_rand(4'd15, ok);
        for (int k = 0; k < 13; k++) begin
            exp_v = (k < 12) ? 15 - k : 15;
            checks++;
            if (!ok || random_index !== 4'(exp_v)) begin
                errors++;
                $display("FAIL random_wired4 step %0d: got %0d expected %0d", k, random_index, exp_v);
            end
            @(posedge clk); #1;
        end
        wait_rand(4'd9, ok);
        cp0_wired_we = 1'b1;
        @(posedge clk); #1;
        cp0_wired_we = 1'b0;
        checks++;
        if (!ok || random_index !== 4'd15) begin
            errors++;
            $display("FAIL random_wired_we: got %0d expected 15", random_index);
        end
        wait_rand(4'd10, ok);
        cp0_wired = 4'd12;
        @(posedge clk); #1;
        checks++;
        if (!ok || random_index !== 4'd15) begin
            errors++;
            $display("FAIL random_wired_raise: got %0d expected 15", random_index);
        end
        cp0_wired = 4'd0;
        for (int n = 0; n < 3; n++) begin
            repeat ($urandom_range(0, 7)) @(posedge clk);
            #1;
            if (n > 0) #0;
            exp_idx = m_rand;
            ent = rand86();
            issue(OP_TLBWR, 4'd3, ent, 1'b0);
            observe(10);
            checks++;
            if (o_wr_cyc != 1 || o_wr_idx !== exp_idx || o_wr_data !== ent) begin
                errors++;
                $display("FAIL tlbwr_index: cycle %0d idx %0d expected cycle 1 idx %0d", o_wr_cyc, o_wr_idx, exp_idx);
            end
        end
    endtask

    task automatic test_reset_mid_probe();
        ent_t p, e;
        int bad;
        p = rand86();
        p.g = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e = rand86();
            e.vpn2 = ~p.vpn2;
            mem[i] = e;
        end
        e = rand86(); e.vpn2 = p.vpn2; e.g = 1'b1; mem[5] = e;
        bad = 0;
        issue(OP_TLBP, 4'd0, p, 1'b0);
        repeat (5) begin
            if (cp0_tlbp !== 1'b0 || done !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        if (cp0_tlbp !== 1'b0 || tlb_wr_en !== 1'b0 || done !== 1'b0) bad++;
        @(posedge clk); #1;
        checks++;
        if ({op_ready, busy, random_index, cp0_tlbp} !== {1'b1, 1'b0, 4'd15, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_probe_state: ready %b busy %b random %0d tlbp %b expected 1 0 15 0",
                     op_ready, busy, random_index, cp0_tlbp);
        end
        rst = 1'b0;
        repeat (20) begin
            if (cp0_tlbp !== 1'b0 || tlb_wr_en !== 1'b0 || done !== 1'b0 || op_ready !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_mid_probe_strobes: %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [85:0] ent;
        ent = rand86();
        mem[2] = rand86();
        issue(OP_TLBR, 4'd2, ent, 1'b1);
        op_type = OP_TLBWI;
        observe(10);
        checks++;
        if (o_wr_cyc != -1 || o_tlbr_cyc != 2 || o_ready_cyc != 3) begin
            errors++;
            $display("FAIL b2b_first: wr %0d tlbr %0d ready %0d expected -1 2 3", o_wr_cyc, o_tlbr_cyc, o_ready_cyc);
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        observe(10);
        checks++;
        if (o_wr_cyc != 1 || o_wr_idx !== 4'd2 || o_wr_data !== ent || o_ready_cyc != 2) begin
            errors++;
            $display("FAIL b2b_pending: wr %0d idx %0d ready %0d expected 1 2 2", o_wr_cyc, o_wr_idx, o_ready_cyc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_tlbwi();
        test_tlbr();
        test_tlbp_directed();
        test_tlbp_random();
        test_random_wired();
        test_reset_mid_probe();
        test_back_to_back();
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tlb_op_sequencer.md
# tlb_op_sequencer

Multi-cycle sequencer for MIPS TLB maintenance instructions (TLBR, TLBWI, TLBWR, TLBP). It sits between the commit stage, the coprocessor-0 register file and the 16-entry TLB array's maintenance port. It issues array reads and writes, scans the array for TLBP, and generates the single-cycle `tlbr`/`tlbp` update strobes that coprocessor-0 consumes. It also owns the Random register.

## Interface
- `NUM_ENTRIES`, 16: TLB entries; index width is 4.
- `ENTRY_W`, 86: packed entry width. Fields: [85:67] VPN2, [66] G, [65:58] ASID, [57:29] Lo0, [28:0] Lo1.
- Reset is `rst`, synchronous, active-high. Clock is `clk`.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `op_valid` in 1: maintenance op request.
- `op_type` in 2: 0 TLBR, 1 TLBWI, 2 TLBWR, 3 TLBP.
- `op_ready` out 1: high only in IDLE.
- `cp0_index` in 4: Index[3:0].
- `cp0_wired` in 4: Wired[3:0].
- `cp0_wired_we` in 1: pulse when Wired is written.
- `cp0_entry` in 86: packed EntryHi/EntryLo0/EntryLo1.
- `tlb_rd_en` out 1: array read request.
- `tlb_rd_idx` out 4: array read index.
- `tlb_rd_data` in 86: read data, valid the cycle after `tlb_rd_en`.
- `tlb_wr_en` out 1: array write strobe.
- `tlb_wr_idx` out 4: array write index.
- `tlb_wr_data` out 86: array write data.
- `cp0_tlbr` out 1: pulse; coprocessor-0 loads `tlbr_data`.
- `tlbr_data` out 86: entry read by TLBR.
- `cp0_tlbp` out 1: pulse; coprocessor-0 loads `probe_miss` and `probe_index`.
- `probe_miss` out 1: Index[31] value.
- `probe_index` out 4: Index[3:0] value.
- `random_index` out 4: current Random value.
- `busy` out 1: equals !`op_ready`.
- `done` out 1: one-cycle pulse when an op completes.

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WRITE, PROBE, DONE.
- Accept: a request is accepted when `op_valid && op_ready`.
- Operand stability: `cp0_entry` and `cp0_index` are held stable by the pipeline while `busy`.
- Decode on accept:
  - TLBR goes to RD_ISSUE.
  - TLBWI and TLBWR go to WRITE.
  - TLBP goes to PROBE.
- TLBWR index: `random_index` is sampled into the write index at accept.
- RD_ISSUE: `tlb_rd_en`=1, `tlb_rd_idx`=`cp0_index`. Next state is RD_WAIT.
- RD_WAIT: `tlbr_data`=`tlb_rd_data`, `cp0_tlbr`=1, `done`=1. Next state is IDLE.
- WRITE: `tlb_wr_en`=1, `tlb_wr_data`=`cp0_entry`, `done`=1. Next state is IDLE.
- PROBE: read is pipelined. Cycle k issues read k (k=0..15) and compares the data from read k-1.
- Match condition: data VPN2 == `cp0_entry`[85:67] && (data G || data ASID == `cp0_entry`[65:58]).
- First match at index m: on the compare cycle, `cp0_tlbp`=1, `probe_miss`=0, `probe_index`=m, `done`=1. Next state is IDLE.
  - The read already in flight is ignored.
  - Because the scan starts at 0, the lowest matching index wins.
- Miss: after the compare of entry 15, `cp0_tlbp`=1, `probe_miss`=1, `probe_index`=0.
- Random: 4-bit down-counter that updates every cycle, including while busy.
  - If `cp0_wired_we`, next value is 15.
  - Otherwise, if `random_index` <= `cp0_wired`, next value is 15.
  - Otherwise, next value is `random_index`-1.
- DONE state: reserved and unreachable; it decodes to IDLE.

## Timing
- Reset values:
  - State IDLE, `op_ready`=1, `busy`=0, `random_index`=15.
  - All strobes 0, `tlb_rd_idx`/`tlb_wr_idx`/`probe_index`=0, `probe_miss`=0.
  - `tlbr_data`=0, `tlb_wr_data`=0.
- Accept edge is t0. Latencies measured from t0:
  - TLBWI/TLBWR: write strobe and `done` in cycle t0+1; `op_ready` high again at t0+2.
  - TLBR: `tlb_rd_en` at t0+1; `cp0_tlbr`/`done` at t0+2.
  - TLBP match at m: `cp0_tlbp` at t0+m+2.
  - TLBP miss: `cp0_tlbp` at t0+17.
- Strobes are mutually exclusive. At most one of `cp0_tlbr`, `cp0_tlbp`, `tlb_wr_en` is high per cycle.
- `tlb_rd_en` and `tlb_wr_en` are never high together.
- Reset mid-operation: `rst` in any state returns to IDLE next edge. No write or CP0 strobe is emitted after reset is sampled.
- `op_valid` while busy is not accepted and is not lost. It is accepted once `op_ready`=1.
- Random wrap: with Wired=0, the sequence is 15,14,…,0,15.
- Wired raised above the current Random value: the next value is 15.

## Structure
- Package `tlb_pkg` holds:
  - the `tlb_op_e` enum (TLBR/TLBWI/TLBWR/TLBP);
  - entry field MSB/LSB constants;
  - `TLB_ENTRIES`=16;
  - the `tlb_seq_state_e` enum.
- One sub-module: `tlb_random_counter` (Random register and wired logic).

## Test plan
- Reset, then TLBWI with Index=5, entry=0x2A…: `tlb_wr_en`@t0+1, idx 5, data equals `cp0_entry`; `done` once; ready at t0+2.
- TLBR Index=9 with array[9]=X: `tlb_rd_idx`=9 @t0+1; `cp0_tlbr`=1 and `tlbr_data`=X @t0+2.
- TLBP with entries 3 and 7 matching (7 global, ASID mismatch): `cp0_tlbp`@t0+5, `probe_index`=3, `probe_miss`=0.
- TLBP with no match, including an entry with the same VPN2, different ASID, G=0: `cp0_tlbp`@t0+17, `probe_miss`=1.
- Random with Wired=4: sequence 15…4,15. `cp0_wired_we` at value 9 gives 15 next. TLBWR writes the index sampled at accept.
- Assert `rst` at t0+6 of a TLBP: no `cp0_tlbp`; IDLE, `random_index`=15, `op_ready`=1 next cycle.
